// File: rtl/mem_if_pkg.sv
// Shared encodings for the processor-side data memory request/stall interface:
// FSM states, sign_mask constants, response error codes and the LED register address.
package mem_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_e;

  // Low three bits select the byte lanes; bit 3 requests sign extension of loads.
  localparam logic [3:0] MASK_B   = 4'b0001;
  localparam logic [3:0] MASK_H   = 4'b0011;
  localparam logic [3:0] MASK_W   = 4'b0111;
  localparam int         SIGN_BIT = 3;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  localparam logic [31:0] DEFAULT_LED_ADDR = 32'h0000_2000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] signed_mask(input logic [3:0] lanes);
    logic [3:0] m;
    m           = lanes;
    m[SIGN_BIT] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mem_mask_decode.sv
// Combinational funct3/store/address decode: produces the memory sign_mask and
// flags illegal funct3 encodings and misaligned accesses.
module mem_mask_decode
  import mem_if_pkg::*;
#(
  parameter logic [31:0] LED_ADDR = DEFAULT_LED_ADDR
) (
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [31:0] addr,
  output logic [3:0]  sign_mask,
  output logic        illegal,
  output logic        misaligned
);

  logic half_access;
  logic word_access;

  always_comb begin
    sign_mask   = '0;
    illegal     = 1'b0;
    half_access = 1'b0;
    word_access = 1'b0;
    case (funct3)
      F3_B: sign_mask = signed_mask(MASK_B);
      F3_H: begin
        sign_mask   = signed_mask(MASK_H);
        half_access = 1'b1;
      end
      F3_W: begin
        sign_mask   = MASK_W;
        word_access = 1'b1;
      end
      F3_BU: begin
        sign_mask = MASK_B;
        illegal   = store;
      end
      F3_HU: begin
        sign_mask   = MASK_H;
        half_access = 1'b1;
        illegal     = store;
      end
      default: illegal = 1'b1;
    endcase
    // Stores have nothing to extend.
    if (store) begin
      sign_mask[SIGN_BIT] = 1'b0;
    end
  end

  // The LED register only takes full-word stores; narrower ones are reported as misaligned.
  assign misaligned = (half_access & addr[0])
                    | (word_access & (addr[1:0] != 2'b00))
                    | (store & (addr == LED_ADDR) & ~word_access);

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline-side initiator for the data memory: accepts one load/store per handshake,
// issues a single-cycle strobe, follows the responder's clk_stall and pulses a response.
module mem_access_unit
  import mem_if_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 8,
  parameter logic [31:0] LED_ADDR    = DEFAULT_LED_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_err_code,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        busy
);

  localparam int               CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_q, store_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             memread_q, memread_d;
  logic             memwrite_q, memwrite_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [1:0]       rsp_code_q, rsp_code_d;

  logic [3:0] dec_mask;
  logic       dec_illegal;
  logic       dec_misaligned;
  logic       accept;

  mem_mask_decode #(
    .LED_ADDR(LED_ADDR)
  ) u_decode (
    .funct3    (req_funct3),
    .store     (req_store),
    .addr      (req_addr),
    .sign_mask (dec_mask),
    .illegal   (dec_illegal),
    .misaligned(dec_misaligned)
  );

  // A stall still high in IDLE belongs to an abandoned transaction; wait it out.
  assign req_ready = (state_q == IDLE) & ~mem_clk_stall & ~reset;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_code_d  = rsp_code_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          store_d = req_store;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          mask_d  = dec_mask;
          if (dec_illegal || dec_misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_code_d  = dec_illegal ? ERR_FUNCT3 : ERR_MISALIGN;
          end else begin
            state_d    = ISSUE;
            memread_d  = ~req_store;
            memwrite_d = req_store;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
      WAIT_ACK: begin
        if (mem_clk_stall) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!mem_clk_stall) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_code_d  = ERR_NONE;
          rsp_rdata_d = store_q ? '0 : mem_read_data;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_code_d  = ERR_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = memread_q;
  assign mem_memwrite   = memwrite_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_err_code   = rsp_code_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a stall-based responder model plus a
// rule-level reference for mask, error code, latency and returned data.
module tb_mem_access_unit;

  localparam int          ACK_TIMEOUT = 8;
  localparam logic [31:0] LED         = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_err_code;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;
  logic        busy;

  mem_access_unit #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .LED_ADDR   (LED)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_store     (req_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .rsp_err_code  (rsp_err_code),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_memwrite  (mem_memwrite),
    .mem_memread   (mem_memread),
    .mem_sign_mask (mem_sign_mask),
    .mem_read_data (mem_read_data),
    .mem_clk_stall (mem_clk_stall),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int txn_id = 0;

  // Responder behaviour for the next strobe
  bit          rsp_never = 1'b0;
  int          rsp_rise  = 1;
  int          rsp_hold  = 2;
  logic [31:0] rsp_data  = '0;

  // Strobe monitor record
  int          strobe_cnt  = 0;
  bit          prev_strobe = 1'b0;
  bit          last_rd     = 1'b0;
  logic [31:0] st_addr     = '0;
  logic [31:0] st_wdata    = '0;
  logic [3:0]  st_mask     = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: access width and signedness straight from the funct3 table.
  function automatic void ref_model(input bit st, input bit [2:0] f3, input logic [31:0] a,
                                    output bit err, output bit [1:0] code, output logic [3:0] mask);
    int bytes;
    bit sext;
    bit mis;
    bytes = 0;
    sext  = 1'b0;
    mis   = 1'b0;
    case (f3)
      3'd0: begin bytes = 1; sext = 1'b1; end
      3'd1: begin bytes = 2; sext = 1'b1; end
      3'd2: bytes = 4;
      3'd4: bytes = st ? 0 : 1;
      3'd5: bytes = st ? 0 : 2;
      default: bytes = 0;
    endcase
    if (bytes != 0) begin
      mis = ((int'(a[1:0]) % bytes) != 0) || (st && (a == LED) && (bytes != 4));
    end
    mask = {sext && !st, (bytes == 1) ? 3'b001 : (bytes == 2) ? 3'b011 : 3'b111};
    code = (bytes == 0) ? 2'b11 : mis ? 2'b01 : 2'b00;
    err  = (code != 2'b00);
  endfunction

  // Responder: raise stall rsp_rise negedges after seeing a strobe, drop it rsp_hold later.
  initial begin
    mem_clk_stall = 1'b0;
    mem_read_data = '0;
    forever begin
      @(negedge clk);
      if ((mem_memread || mem_memwrite) && !rsp_never) begin
        repeat (rsp_rise) @(negedge clk);
        mem_clk_stall = 1'b1;
        mem_read_data = $urandom;
        repeat (rsp_hold) @(negedge clk);
        mem_clk_stall = 1'b0;
        mem_read_data = rsp_data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_memread || mem_memwrite) begin
        check_val("strobe_exclusive", 32'(mem_memread & mem_memwrite), 32'd0);
        check_val("strobe_one_cycle", 32'(prev_strobe), 32'd0);
        strobe_cnt++;
        last_rd  = mem_memread;
        st_addr  = mem_addr;
        st_wdata = mem_write_data;
        st_mask  = mem_sign_mask;
      end
      prev_strobe = mem_memread | mem_memwrite;
    end
  end

  task automatic do_req(input bit st, input bit [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit never, input int rise, input int hold, input logic [31:0] rd,
                        input bit keep);
    bit          e;
    bit [1:0]    c;
    logic [3:0]  m;
    bit          issued;
    int          exp_lat;
    int          lat;
    int          guard;
    int          s0;
    logic [31:0] exp_rdata;
    ref_model(st, f3, a, e, c, m);
    issued = !e;
    if (e) begin
      exp_lat = 1;
    end else if (never) begin
      exp_lat = ACK_TIMEOUT + 2;
      e       = 1'b1;
      c       = 2'b10;
    end else begin
      exp_lat = rise + hold + 2;
    end
    exp_rdata = (e || st) ? 32'd0 : rd;
    rsp_never = never;
    rsp_rise  = rise;
    rsp_hold  = hold;
    rsp_data  = rd;

    tick();
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_val("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    s0 = strobe_cnt;
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;

    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rsp_valid && lat < 40);
    check_val("rsp_latency", 32'(lat), 32'(exp_lat));
    check_val("rsp_err", 32'(rsp_err), 32'(e));
    check_val("rsp_err_code", 32'(rsp_err_code), 32'(c));
    check_val("rsp_rdata", rsp_rdata, exp_rdata);
    check_val("ready_in_resp", 32'(req_ready), 32'd0);
    check_val("busy_in_resp", 32'(busy), 32'd1);
    check_val("strobe_count", 32'(strobe_cnt - s0), 32'(issued));
    if (issued) begin
      check_val("strobe_kind", 32'(last_rd), 32'(!st));
      check_val("mem_addr", st_addr, a);
      check_val("mem_sign_mask", 32'(st_mask), 32'(m));
      if (st) check_val("mem_write_data", st_wdata, wd);
      check_val("mem_addr_held", mem_addr, a);
    end
    $display("txn %0d: %s f3=%0d addr=%08h lat=%0d err=%0d code=%0d rdata=%08h",
             txn_id, st ? "ST" : "LD", f3, a, lat, rsp_err, rsp_err_code, rsp_rdata);
    txn_id++;
    if (!keep) begin
      tick();
      check_val("rsp_pulse_end", 32'(rsp_valid), 32'd0);
      check_val("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int guard;
    bit st;
    bit [2:0] f3;
    logic [31:0] a;

    // Request held valid through reset must not be taken.
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_1000;
    req_wdata  = '0;
    repeat (3) tick();
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_strobes", 32'({mem_memread, mem_memwrite}), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_sign_mask", 32'(mem_sign_mask), 32'd0);
    check_val("rst_rsp_fields", {rsp_rdata[29:0], rsp_err_code}, 32'd0);
    reset     = 1'b0;
    req_valid = 1'b0;
    tick();
    check_val("rst_no_accept", 32'(busy), 32'd0);
    check_val("rst_no_strobe", 32'(strobe_cnt), 32'd0);

    // Directed cases
    do_req(1'b0, 3'd2, 32'h0000_1004, 32'h0, 1'b0, 1, 2, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 1'b0, 1, 2, 32'h1234_5678, 1'b0);
    do_req(1'b0, 3'd1, 32'h0000_1001, 32'h0, 1'b0, 1, 2, 32'h0, 1'b0);
    do_req(1'b0, 3'd2, 32'h0000_1010, 32'h0, 1'b1, 1, 1, 32'h0, 1'b0);
    do_req(1'b0, 3'd2, 32'h0000_1014, 32'h0, 1'b0, ACK_TIMEOUT, 1, 32'hCAFE_F00D, 1'b0);
    do_req(1'b1, 3'd2, LED, 32'h0000_000F, 1'b0, 2, 1, 32'h0, 1'b0);
    do_req(1'b1, 3'd0, LED, 32'h0000_0001, 1'b0, 1, 2, 32'h0, 1'b0);
    do_req(1'b1, 3'd4, 32'h0000_1000, 32'h0, 1'b0, 1, 2, 32'h0, 1'b0);
    do_req(1'b0, 3'd3, 32'h0000_1000, 32'h0, 1'b0, 1, 2, 32'h0, 1'b0);
    do_req(1'b0, 3'd5, 32'h0000_1002, 32'h0, 1'b0, 3, 3, 32'h0000_8001, 1'b0);

    // Reset while the responder is stalling; its eventual data must be dropped.
    rsp_never = 1'b0;
    rsp_rise  = 1;
    rsp_hold  = 6;
    rsp_data  = 32'h0BAD_0BAD;
    tick();
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_1008;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) tick();
    check_val("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("mid_busy_cleared", 32'(busy), 32'd0);
    check_val("mid_strobes", 32'({mem_memread, mem_memwrite}), 32'd0);
    check_val("mid_mem_addr", mem_addr, 32'd0);
    guard = 0;
    while (mem_clk_stall && guard < 20) begin
      check_val("stale_ready", 32'(req_ready), 32'd0);
      check_val("stale_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      guard++;
    end
    check_val("stall_released", 32'(mem_clk_stall), 32'd0);
    check_val("ready_after_stall", 32'(req_ready), 32'd1);
    check_val("no_late_rsp", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'd2, 32'h0000_100C, 32'h0, 1'b0, 1, 2, 32'h600D_DA7A, 1'b0);

    // Back-to-back with req_valid held high
    do_req(1'b0, 3'd2, 32'h0000_1020, 32'h0, 1'b0, 1, 2, 32'h1111_2222, 1'b1);
    do_req(1'b1, 3'd2, 32'h0000_1024, 32'h5555_AAAA, 1'b0, 1, 1, 32'h0, 1'b1);
    do_req(1'b0, 3'd0, 32'h0000_1027, 32'h0, 1'b0, 2, 2, 32'hFFFF_FF80, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = LED + 32'($urandom_range(0, 3));
      else a = 32'h0000_1000 + 32'($urandom_range(0, 255));
      do_req(st, f3, a, $urandom, ($urandom_range(0, 9) == 0),
             int'($urandom_range(1, ACK_TIMEOUT)), int'($urandom_range(1, 3)), $urandom,
             (i < 59) && ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Processor-side initiator for the data memory request/stall interface.
- Accepts one load/store per valid/ready handshake from the pipeline and checks alignment.
- Maps funct3 to the 4-bit sign_mask and drives a single-cycle memread/memwrite strobe.
- Tracks the responder's clk_stall rise/fall, then returns load data or store completion on a one-cycle response pulse.

Parameters:
- ACK_TIMEOUT, 8: max cycles in WAIT_ACK for mem_clk_stall to rise before a timeout error is returned.
- LED_ADDR, 32'h2000: LED register address; stores to it are legal word-only, any other width is a misaligned error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors
- rsp_err  out  1  request failed
- rsp_err_code  out  2  01 misaligned, 10 ack timeout, 11 illegal funct3
- mem_addr  out  32  to data memory addr
- mem_write_data  out  32  to data memory write_data
- mem_memwrite  out  1  write strobe
- mem_memread  out  1  read strobe
- mem_sign_mask  out  4  to data memory sign_mask
- mem_read_data  in  32  from data memory read_data
- mem_clk_stall  in  1  from data memory clk_stall
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state IDLE; all outputs 0; req_ready is combinational (see IDLE).
- Sign_mask encoding is a registered decode of funct3:
  - 000 -> 1001 (LB/SB)
  - 001 -> 1011 (LH/SH)
  - 010 -> 0111 (LW/SW)
  - 100 -> 0001 (LBU)
  - 101 -> 0011 (LHU)
  - Bit 3 is forced to 0 for stores.
  - Store funct3 100/101, and funct3 011/110/111 for either op, are illegal.
- IDLE:
  - req_ready = ~mem_clk_stall.
  - On req_valid & req_ready, latch addr, wdata, store, mask.
  - If the request is illegal or misaligned (half with addr[0]=1; word with addr[1:0]!=0), go to RESP with the error set. No strobe is issued.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_memread = ~store, mem_memwrite = store.
  - mem_addr, mem_write_data and mem_sign_mask are registered and held stable from ISSUE until IDLE is re-entered.
  - Next state is WAIT_ACK; the timeout counter clears to 0.
- WAIT_ACK:
  - Strobes are low.
  - If mem_clk_stall=1, go to WAIT_DONE.
  - Else, if the counter reaches ACK_TIMEOUT-1, go to RESP with code 10.
  - Otherwise increment the counter.
- WAIT_DONE: wait for mem_clk_stall=0. On that cycle, capture mem_read_data (loads only) and go to RESP.
- RESP:
  - rsp_valid=1 for one cycle; rsp_rdata/rsp_err/rsp_err_code are valid only in this cycle.
  - Next state is IDLE; req_ready stays 0 during RESP.
- Latency:
  - Legal request: accept edge at t0, strobe in cycle t0+1, rsp_valid in cycle t0+5 with a nominal responder (stall rises after t1, falls after t3).
  - Error request: rsp_valid in cycle t0+1.
- No response backpressure. rsp_valid is a pulse; the consumer must take it.
- Strobes are never high outside ISSUE. This prevents the responder from re-triggering when it returns to IDLE.
- mem_clk_stall already high while in IDLE (e.g. after reset mid-transaction): hold req_ready=0 until it falls. The stale read_data is discarded.
- Reset in any state returns to IDLE within one edge with strobes low. The in-flight response is dropped; no rsp_valid is emitted.
- Simultaneous reset and req_valid: reset wins and the request is not accepted.

Decomposition:
- Shared package mem_if_pkg holds:
  - state encodings IDLE/ISSUE/WAIT_ACK/WAIT_DONE/RESP;
  - the sign_mask constants MASK_B/MASK_H/MASK_W and the sign bit;
  - the error codes;
  - LED_ADDR.
- One natural sub-module: mem_mask_decode (combinational funct3+store+addr[1:0] -> sign_mask, illegal, misaligned). The FSM stays in the top.

Test Plan:
- LW at 0x1004, responder model returns 0xDEADBEEF -> one strobe cycle with mem_sign_mask=0111; rsp_valid 5 cycles after accept; rsp_rdata=0xDEADBEEF, rsp_err=0.
- SB at 0x1003, wdata 0x000000A5 -> mem_memwrite pulse of exactly 1 cycle; mem_sign_mask=0001; mem_addr=0x1003; rsp_err=0.
- LH at 0x1001 -> no strobe; rsp_valid 1 cycle after accept; rsp_err=1, code 01.
- Responder model never raises stall -> rsp_err=1, code 10, exactly ACK_TIMEOUT cycles after leaving ISSUE; next request accepted.
- Reset asserted in WAIT_DONE while stall=1 -> outputs 0, no rsp_valid; req_ready stays 0 until stall falls; the next LW completes correctly.
- Back-to-back LW/SW with req_valid held high -> second accept only after RESP; memread/memwrite never high simultaneously or for more than 1 cycle.
